// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage; PC and 1-cycle imem reads (imem_*), redirect (PCsrc/PCTarget), FIFO of {instr, pc} to decode (instr*)
module instr_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] PCTarget,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] fetch_pc, req_pc;
  logic inflight, push, pop, issue;
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count, occ;
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_a [DEPTH];
  assign instr_valid = count != '0;
  assign pop = instr_valid & instr_ready & !PCsrc;
  assign push = inflight & !PCsrc;
  assign occ = count + CW'(inflight) - CW'(pop);
  assign issue = !rst & !PCsrc & (occ < CW'(DEPTH));
  assign imem_req = issue;
  assign imem_addr = fetch_pc;
  assign instr = instr_valid ? mem_d[rd] : '0;
  assign instr_pc = instr_valid ? mem_a[rd] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      inflight <= 1'b0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (PCsrc) begin
      fetch_pc <= PCTarget & ~ADDR_WIDTH'(3);
      inflight <= 1'b0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        req_pc <= fetch_pc;
      end
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_d[wr] <= imem_rdata;
      mem_a[wr] <= req_pc;
    end
  assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized in-order stream check of instr_fetch against a request/accept model
module tb_instr_fetch;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] RPC = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic PCsrc = 1'b0;
  logic [AW-1:0] PCTarget = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic instr_valid;
  logic instr_ready = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int outst = 0;
  int q[$];
  logic [AW-1:0] exp_req = RPC;
  logic [AW-1:0] exp_acc = RPC;
  logic [AW-1:0] last_pc = '0;
  logic last_stall = 1'b0;
  instr_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .PCsrc(PCsrc), .PCTarget(PCTarget), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr | 32'h13;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    exp_req = RPC;
    exp_acc = RPC;
    outst = 0;
    q.delete();
    last_stall = 1'b0;
  endtask
  task automatic check_rst();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
  endtask
  task automatic step(logic r, logic rdy, logic br, logic [AW-1:0] tgt);
    logic acc;
    @(negedge clk);
    rst = r;
    instr_ready = rdy;
    PCsrc = br;
    PCTarget = tgt;
    #1;
    if (r) begin
      check_rst();
      model_reset();
      cyc++;
      return;
    end
    check("valid", instr_valid, q.size() > 0 && q[0] <= cyc - 2);
    check("instr", instr, instr_valid ? (instr_pc | 32'h13) : 32'h0);
    if (!instr_valid) check("pc_empty", instr_pc, 0);
    if (last_stall) check("hold_pc", instr_pc, last_pc);
    acc = instr_valid & rdy & !br;
    if (acc) begin
      check("pc_order", instr_pc, exp_acc);
      exp_acc += 4;
      if (q.size() > 0) void'(q.pop_front());
      outst--;
    end
    check("req", imem_req, !br && outst < DEPTH);
    if (imem_req) begin
      check("req_addr", imem_addr, exp_req);
      exp_req += 4;
      q.push_back(cyc);
      outst++;
    end
    if (br) begin
      exp_req = tgt & ~32'h3;
      exp_acc = tgt & ~32'h3;
      q.delete();
      outst = 0;
    end
    last_stall = instr_valid & !rdy & !br;
    last_pc = instr_pc;
    cyc++;
  endtask
  task automatic async_rst();
    @(negedge clk);
    instr_ready = 1'b1;
    PCsrc = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_rst();
    model_reset();
    cyc++;
    step(1, 1, 0, 0);
  endtask
  initial begin
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h103);
    repeat (6) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h40);
    step(0, 1, 1, 32'h80);
    repeat (6) step(0, 1, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFF4);
    repeat (8) step(0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    async_rst();
    repeat (6) step(0, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_rst();
      else step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
